// File: rtl/clk_div_ctrl_if.sv
// Handshake/status bundle between the divided-clock controller and its user.
// Optional period_cnt member exists when CLK_DIV_CTRL_PERIOD_CNT_EN is defined.
interface clk_div_ctrl_if #(
    parameter int BITS_HALF_RATIO = 5
);
    logic                       run_en;
    logic                       cfg_valid;
    logic [BITS_HALF_RATIO-1:0] cfg_half_ratio;
    logic                       cfg_ready;
    logic                       cfg_err;
    logic                       clk_divided;
    logic                       rise_en;
    logic                       fall_en;
    logic [BITS_HALF_RATIO-1:0] half_ratio_cur;
    logic                       busy;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [31:0]                period_cnt;

    modport master (
        output run_en, cfg_valid, cfg_half_ratio,
        input  cfg_ready, cfg_err, clk_divided, rise_en, fall_en, half_ratio_cur, busy,
        input  period_cnt
    );
    modport slave (
        input  run_en, cfg_valid, cfg_half_ratio,
        output cfg_ready, cfg_err, clk_divided, rise_en, fall_en, half_ratio_cur, busy,
        output period_cnt
    );
`else
    modport master (
        output run_en, cfg_valid, cfg_half_ratio,
        input  cfg_ready, cfg_err, clk_divided, rise_en, fall_en, half_ratio_cur, busy
    );
    modport slave (
        input  run_en, cfg_valid, cfg_half_ratio,
        output cfg_ready, cfg_err, clk_divided, rise_en, fall_en, half_ratio_cur, busy
    );
`endif
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable divided-clock controller: glitch-free ratio changes at period ends, stops low.
// Optional feature macro: CLK_DIV_CTRL_PERIOD_CNT_EN adds a free-running completed-period counter.
module clk_div_ctrl #(
    parameter int MAX_HALF_RATIO     = 16,
    parameter int BITS_HALF_RATIO    = 5,
    parameter int DEFAULT_HALF_RATIO = 4
) (
    input logic           clk,
    input logic           rst,
    clk_div_ctrl_if.slave bus
);
    // STOPPING is a reserved encoding; stop sequencing is handled inside RUN.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOPPING = 2'd2} state_t;

    localparam logic [BITS_HALF_RATIO-1:0] ONE   = BITS_HALF_RATIO'(1);
    localparam logic [BITS_HALF_RATIO-1:0] MAX_V = BITS_HALF_RATIO'(MAX_HALF_RATIO);
    localparam logic [BITS_HALF_RATIO-1:0] DEF_V = BITS_HALF_RATIO'(DEFAULT_HALF_RATIO);

    state_t                     state;
    logic [BITS_HALF_RATIO-1:0] ctr;
    logic [BITS_HALF_RATIO-1:0] half_ratio_cur;
    logic [BITS_HALF_RATIO-1:0] pend_val;
    logic                       pending;
    logic                       clk_div;
    logic                       cfg_err;
    logic                       running, eop, pend, xfer, legal;

    assign running = (state != IDLE);
    assign eop     = (ctr == half_ratio_cur - ONE);
    assign pend    = running & eop & clk_div;
    assign xfer    = bus.cfg_valid & ~pending;
    assign legal   = (bus.cfg_half_ratio != '0) && (bus.cfg_half_ratio <= MAX_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ctr            <= '0;
            clk_div        <= 1'b0;
            half_ratio_cur <= DEF_V;
            pend_val       <= '0;
            pending        <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            cfg_err <= xfer & ~legal;
            // xfer needs ~pending and apply needs pending, so they never collide;
            // a transfer coinciding with pend therefore waits for the next boundary.
            if (xfer && legal) begin
                pending  <= 1'b1;
                pend_val <= bus.cfg_half_ratio;
            end else if (pending && (!running || pend)) begin
                pending        <= 1'b0;
                half_ratio_cur <= pend_val;
            end

            case (state)
                IDLE: begin
                    ctr     <= '0;
                    clk_div <= 1'b0;
                    if (bus.run_en) state <= RUN;
                end
                default: begin
                    if (pend && !bus.run_en) begin
                        state   <= IDLE;
                        ctr     <= '0;
                        clk_div <= 1'b0;
                    end else begin
                        state <= RUN;
                        ctr   <= eop ? '0 : ctr + ONE;
                        if (eop) clk_div <= ~clk_div;
                    end
                end
            endcase
        end
    end

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [31:0] period_cnt;

    always_ff @(posedge clk) begin
        if (rst)       period_cnt <= '0;
        else if (pend) period_cnt <= period_cnt + 32'd1;
    end

    assign bus.period_cnt = period_cnt;
`endif

    assign bus.cfg_ready      = ~pending;
    assign bus.cfg_err        = cfg_err;
    assign bus.clk_divided    = clk_div;
    assign bus.rise_en        = eop & ~clk_div & (state == RUN);
    assign bus.fall_en        = eop & clk_div;
    assign bus.half_ratio_cur = half_ratio_cur;
    assign bus.busy           = running;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: directed scenarios plus random traffic against a
// period-position reference model.
module tb_clk_div_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    clk_div_ctrl_if #(.BITS_HALF_RATIO(5)) bus ();

    clk_div_ctrl #(
        .MAX_HALF_RATIO(16), .BITS_HALF_RATIO(5), .DEFAULT_HALF_RATIO(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: position within the current full period (0 .. 2*hr-1); low half first.
    bit          m_run;
    int          m_pos;
    int          m_hr;
    bit          m_pend;
    int          m_pval;
    bit          m_err;
    int unsigned m_pcnt;

    function automatic bit exp_clk();  return m_run && (m_pos >= m_hr);          endfunction
    function automatic bit exp_rise(); return m_run && (m_pos == m_hr - 1);      endfunction
    function automatic bit exp_fall(); return m_run && (m_pos == 2 * m_hr - 1);  endfunction

    task automatic model_step();
        bit xfer, legal, pe, apply;
        int new_hr;
        if (rst) begin
            m_run = 0; m_pos = 0; m_hr = 4; m_pend = 0; m_pval = 0; m_err = 0; m_pcnt = 0;
        end else begin
            xfer   = bus.cfg_valid && !m_pend;
            legal  = (bus.cfg_half_ratio >= 1) && (bus.cfg_half_ratio <= 16);
            pe     = m_run && (m_pos == 2 * m_hr - 1);
            apply  = m_pend && (!m_run || pe);
            new_hr = apply ? m_pval : m_hr;
            m_err  = xfer && !legal;
            if (apply) m_pend = 0;
            if (xfer && legal) begin
                m_pend = 1;
                m_pval = int'(bus.cfg_half_ratio);
            end
            if (!m_run) begin
                if (bus.run_en) begin m_run = 1; m_pos = 0; end
            end else if (pe) begin
                m_pcnt++;
                m_pos = 0;
                if (!bus.run_en) m_run = 0;
            end else begin
                m_pos++;
            end
            m_hr = new_hr;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1; bus.run_en = 0; bus.cfg_valid = 0; bus.cfg_half_ratio = '0;
        tick(); tick();
        rst = 0;
        checks++; if (bus.clk_divided !== 1'b0) begin failures++; $display("FAIL reset_clk got=%b exp=0", bus.clk_divided); end
        checks++; if (bus.half_ratio_cur !== 5'd4) begin failures++; $display("FAIL reset_hr got=%0d exp=4", bus.half_ratio_cur); end
        checks++; if (bus.cfg_ready !== 1'b1 || bus.cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg got rdy=%b err=%b exp rdy=1 err=0", bus.cfg_ready, bus.cfg_err); end
        checks++; if ({bus.rise_en, bus.fall_en, bus.busy} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.rise_en, bus.fall_en, bus.busy}); end
    endtask

    task automatic test_default_run();
        int first = -1, nr = 0, nf = 0, nh = 0;
        bus.run_en = 1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (bus.clk_divided !== exp_clk() || bus.rise_en !== exp_rise() || bus.fall_en !== exp_fall()) begin
                failures++;
                $display("FAIL default_run cyc=%0d got clk/r/f=%b%b%b exp=%b%b%b", i, bus.clk_divided, bus.rise_en, bus.fall_en, exp_clk(), exp_rise(), exp_fall());
            end
            if (bus.rise_en) begin nr++; if (first < 0) first = i; end
            if (bus.fall_en) nf++;
            if (bus.clk_divided) nh++;
            tick();
        end
        checks++; if (first != 4) begin failures++; $display("FAIL first_rise got=%0d exp=4", first); end
        checks++; if (nr != 2 || nf != 2) begin failures++; $display("FAIL strobe_count got r=%0d f=%0d exp r=2 f=2", nr, nf); end
        checks++; if (nh != 8) begin failures++; $display("FAIL high_cycles got=%0d exp=8", nh); end
    endtask

    task automatic test_cfg_apply();
        int n = 0, gap = 0;
        while (bus.clk_divided !== 1'b1 && n < 20) begin tick(); n++; end
        bus.cfg_valid = 1; bus.cfg_half_ratio = 5'd2;
        tick();
        bus.cfg_valid = 0;
        checks++; if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_drop got=%b exp=0", bus.cfg_ready); end
        checks++; if (bus.half_ratio_cur !== 5'd4) begin failures++; $display("FAIL hr_hold got=%0d exp=4", bus.half_ratio_cur); end
        n = 0;
        while (bus.half_ratio_cur !== 5'd2 && n < 20) begin
            checks++;
            if (bus.half_ratio_cur !== 5'(m_hr) || bus.clk_divided !== exp_clk()) begin
                failures++;
                $display("FAIL apply_wait got hr=%0d clk=%b exp hr=%0d clk=%b", bus.half_ratio_cur, bus.clk_divided, m_hr, exp_clk());
            end
            tick(); n++;
        end
        checks++; if (n >= 20) begin failures++; $display("FAIL apply_timeout got hr=%0d exp=2", bus.half_ratio_cur); end
        checks++; if (bus.cfg_ready !== 1'b1 || bus.clk_divided !== 1'b0) begin failures++; $display("FAIL after_apply got rdy=%b clk=%b exp rdy=1 clk=0", bus.cfg_ready, bus.clk_divided); end
        n = 0;
        while (bus.rise_en !== 1'b1 && n < 10) begin tick(); n++; end
        tick(); gap = 1;
        while (bus.rise_en !== 1'b1 && gap < 20) begin tick(); gap++; end
        checks++; if (gap != 4) begin failures++; $display("FAIL new_period got=%0d exp=4", gap); end
    endtask

    task automatic test_cfg_illegal();
        logic [4:0] bad [2];
        bad[0] = 5'd0; bad[1] = 5'd17;
        for (int k = 0; k < 2; k++) begin
            bus.cfg_valid = 1; bus.cfg_half_ratio = bad[k];
            tick();
            bus.cfg_valid = 0;
            checks++; if (bus.cfg_err !== 1'b1 || bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL illegal_err v=%0d got err=%b rdy=%b exp err=1 rdy=1", bad[k], bus.cfg_err, bus.cfg_ready); end
            tick();
            checks++; if (bus.cfg_err !== 1'b0 || bus.half_ratio_cur !== 5'd2) begin failures++; $display("FAIL illegal_after v=%0d got err=%b hr=%0d exp err=0 hr=2", bad[k], bus.cfg_err, bus.half_ratio_cur); end
        end
    endtask

    task automatic test_stop();
        int n = 0, nstr = 0;
        bus.cfg_valid = 1; bus.cfg_half_ratio = 5'd3;
        tick();
        bus.cfg_valid = 0;
        while (!(m_run && m_hr == 3 && m_pos == 1) && n < 40) begin tick(); n++; end
        checks++; if (bus.half_ratio_cur !== 5'd3 || bus.clk_divided !== 1'b0) begin failures++; $display("FAIL stop_setup got hr=%0d clk=%b exp hr=3 clk=0", bus.half_ratio_cur, bus.clk_divided); end
        bus.run_en = 0;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin
            if (bus.rise_en || bus.fall_en) nstr++;
            tick(); n++;
        end
        checks++; if (n != 5 || nstr != 2) begin failures++; $display("FAIL stop_len got cyc=%0d strobes=%0d exp cyc=5 strobes=2", n, nstr); end
        checks++; if (bus.clk_divided !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL stop_idle got clk=%b busy=%b exp 0 0", bus.clk_divided, bus.busy); end
        nstr = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rise_en || bus.fall_en || bus.clk_divided) nstr++;
            tick();
        end
        checks++; if (nstr != 0) begin failures++; $display("FAIL idle_quiet got=%0d exp=0", nstr); end
    endtask

    task automatic test_ratio1();
        int n = 0;
        logic prev;
        bus.cfg_valid = 1; bus.cfg_half_ratio = 5'd1;
        tick();
        bus.cfg_valid = 0;
        tick();
        checks++; if (bus.half_ratio_cur !== 5'd1) begin failures++; $display("FAIL hr1_load got=%0d exp=1", bus.half_ratio_cur); end
        bus.run_en = 1;
        tick();
        prev = ~bus.clk_divided;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ((bus.rise_en ^ bus.fall_en) !== 1'b1 || bus.clk_divided === prev || bus.clk_divided !== exp_clk()) begin
                failures++;
                $display("FAIL ratio1 cyc=%0d got clk=%b r=%b f=%b exp clk=%b one strobe", i, bus.clk_divided, bus.rise_en, bus.fall_en, exp_clk());
            end
            prev = bus.clk_divided;
            tick();
        end
        while (bus.clk_divided !== 1'b1 && n < 4) begin tick(); n++; end
        rst = 1; bus.run_en = 0;
        tick();
        rst = 0;
        checks++; if (bus.clk_divided !== 1'b0 || bus.half_ratio_cur !== 5'd4 || bus.busy !== 1'b0) begin failures++; $display("FAIL mid_reset got clk=%b hr=%0d busy=%b exp 0 4 0", bus.clk_divided, bus.half_ratio_cur, bus.busy); end
    endtask

    task automatic test_random();
        int bad = 0;
        bus.run_en = 0; bus.cfg_valid = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 24) == 0) bus.run_en = ~bus.run_en;
            bus.cfg_valid = ($urandom_range(0, 7) == 0);
            bus.cfg_half_ratio = 5'($urandom_range(0, 20));
            tick();
            checks++;
            if (bus.clk_divided !== exp_clk() || bus.rise_en !== exp_rise() || bus.fall_en !== exp_fall()
                || bus.busy !== m_run || bus.cfg_ready !== !m_pend || bus.cfg_err !== m_err
                || bus.half_ratio_cur !== 5'(m_hr)) begin
                failures++; bad++;
                if (bad <= 10)
                    $display("FAIL random cyc=%0d got clk/r/f/busy/rdy/err=%b%b%b%b%b%b hr=%0d exp=%b%b%b%b%b%b hr=%0d",
                             i, bus.clk_divided, bus.rise_en, bus.fall_en, bus.busy, bus.cfg_ready, bus.cfg_err, bus.half_ratio_cur,
                             exp_clk(), exp_rise(), exp_fall(), m_run, !m_pend, m_err, m_hr);
            end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
            checks++;
            if (bus.period_cnt !== m_pcnt) begin
                failures++; bad++;
                if (bad <= 10) $display("FAIL random_pcnt cyc=%0d got=%0d exp=%0d", i, bus.period_cnt, m_pcnt);
            end
`endif
        end
        bus.cfg_valid = 0;
    endtask

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    task automatic run_periods(input int want);
        int nf = 0, n = 0;
        bus.run_en = 1;
        while (bus.busy !== 1'b0 || nf == 0) begin
            if (bus.fall_en === 1'b1) begin
                nf++;
                if (nf == want) bus.run_en = 0;
            end
            tick(); n++;
            if (n > 200) break;
        end
        checks++; if (n > 200) begin failures++; $display("FAIL pcnt_timeout got fall=%0d exp=%0d", nf, want); end
    endtask

    task automatic test_period_cnt();
        rst = 1; bus.run_en = 0; bus.cfg_valid = 0;
        tick();
        rst = 0;
        checks++; if (bus.period_cnt !== 32'd0) begin failures++; $display("FAIL pcnt_reset got=%0d exp=0", bus.period_cnt); end
        bus.cfg_valid = 1; bus.cfg_half_ratio = 5'd2;
        tick();
        bus.cfg_valid = 0;
        tick();
        run_periods(5);
        checks++; if (bus.period_cnt !== 32'd5) begin failures++; $display("FAIL pcnt_first got=%0d exp=5", bus.period_cnt); end
        run_periods(3);
        checks++; if (bus.period_cnt !== 32'd8) begin failures++; $display("FAIL pcnt_total got=%0d exp=8", bus.period_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_default_run();
        test_cfg_apply();
        test_cfg_illegal();
        test_stop();
        test_ratio1();
        test_random();
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        test_period_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time-programmable controller for the divided-clock domain used by the SpMV merge pipeline.
- Generates the divided clock level plus single-cycle rise/fall enable strobes for fast-domain logic.
- Accepts new half-ratio settings over a valid/ready handshake and applies them only at a full-period boundary, so the output never has a short or partial phase.
- Sequences start and stop of the divided domain so the clock always stops low after a complete period.

Parameters:
MAX_HALF_RATIO, 16, largest legal half-period length in clk cycles.
BITS_HALF_RATIO, 5, width of half-ratio fields; must satisfy 2^BITS_HALF_RATIO > MAX_HALF_RATIO.
DEFAULT_HALF_RATIO, 4, half-ratio loaded at reset; must be in 1..MAX_HALF_RATIO.

Ports:
clk  in  1  single clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
run_en  in  1  level; 1 = divided clock runs, 0 = stop at the next period end.
cfg_valid  in  1  new half-ratio offered.
cfg_half_ratio  in  BITS_HALF_RATIO  requested half-period in clk cycles.
cfg_ready  out  1  controller can accept a config; transfer occurs when cfg_valid & cfg_ready.
cfg_err  out  1  one-cycle pulse: accepted config was illegal (0 or >MAX) and discarded.
clk_divided  out  1  divided clock level.
rise_en  out  1  one-cycle strobe, high in the cycle before clk_divided goes 0->1.
fall_en  out  1  one-cycle strobe, high in the cycle before clk_divided goes 1->0.
half_ratio_cur  out  BITS_HALF_RATIO  half-ratio currently in effect.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at posedge), all registered:
  - state=IDLE, ctr=0, clk_divided=0, half_ratio_cur=DEFAULT_HALF_RATIO.
  - No pending config; cfg_ready=1, cfg_err=0.
  - rise_en=0, fall_en=0, busy=0.
  - Reset mid-operation aborts immediately; no period completion.
- Counter `ctr` (BITS_HALF_RATIO bits), end-of-phase condition `eop` = (ctr == half_ratio_cur-1):
  - In RUN/STOPPING: ctr wraps to 0 on eop, otherwise increments.
  - In IDLE: ctr held at 0.
- clk_divided toggles on eop in RUN/STOPPING. Full period = 2*half_ratio_cur clk cycles.
- rise_en = eop & ~clk_divided & (state==RUN). fall_en = eop & clk_divided. Both are combinational from registered state; at most one is high per cycle.
- Period end `pend` = eop & clk_divided.
- States:
  - IDLE:
    - run_en=1 -> RUN next cycle; ctr=0, clk_divided=0.
    - First rise_en occurs when ctr reaches half_ratio_cur-1.
  - RUN:
    - pend & ~run_en -> IDLE; clk_divided becomes 0, ctr=0.
    - Otherwise stay in RUN.
  - STOPPING: reserved encoding, treated as RUN with run_en=0. Implementations may merge it into RUN.
- Config handshake:
  - cfg_ready = ~pending.
  - On transfer with a legal value (1..MAX_HALF_RATIO): store it as pending and set pending=1.
  - On transfer with an illegal value: pending stays 0 and cfg_err pulses the next cycle.
- Config apply:
  - In IDLE, a pending value loads into half_ratio_cur on the next cycle, and pending clears.
  - In RUN, a pending value loads only at pend; the new ratio governs the next period.
  - Transfer in the same cycle as pend, while in RUN: the value is not applied at that boundary. It waits for the following pend.
  - pend with both a pending config and run_en=0: apply the config and go to IDLE in the same cycle.
  - IDLE with run_en=1 and a pending config in the same cycle: load the config, and the first period uses the new ratio.
- Half ratio 1: clk_divided toggles every cycle (divide by 2). rise_en and fall_en alternate every cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined:
  - Adds output period_cnt [31:0], reset to 0.
  - Increments by 1 on every pend and wraps at 2^32.
  - Not cleared by stop; cleared only by rst.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then run_en=1, default ratio 4 -> clk_divided has 8-cycle period (4 high, 4 low). First rise_en in the 4th cycle after entering RUN. rise_en/fall_en each pulse once per period.
- In RUN with ratio 4, transfer cfg_half_ratio=2 mid-high-phase -> cfg_ready drops next cycle. half_ratio_cur stays 4 until pend, then becomes 2, and the next period is 4 cycles. cfg_ready returns to 1 after apply.
- Transfer cfg_half_ratio=0, then 17 -> cfg_err pulses once for each. half_ratio_cur unchanged. cfg_ready stays 1.
- Deassert run_en at ctr=1 of the low phase, ratio 3 -> controller finishes the low and high phases, then enters IDLE with clk_divided=0. busy falls in the same cycle. No further strobes.
- Ratio 1, run_en=1 for 10 cycles -> clk_divided alternates every cycle, and a rise_en or fall_en is present every cycle. Assert rst mid-high -> next cycle clk_divided=0, half_ratio_cur=4.
- With CLK_DIV_CTRL_PERIOD_CNT_EN defined, run 5 periods at ratio 2, stop, then run 3 more -> period_cnt=8. Without the macro, the design compiles and the other tests pass unchanged.
